// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties) instead of round-robin.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_PORTS  = 2;
  localparam logic PORT0    = 1'b0;
  localparam logic PORT1    = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way picker: a lone requester always wins; ties go away from `last`.
// With MEM_ARB_FIXED_PRIO_EN defined, ties go to port 0 and `last` is not present.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifndef MEM_ARB_FIXED_PRIO_EN
  input  logic       last,
`endif
  output logic       winner
);

  always_comb begin
    winner = PORT0;
    if (req == 2'b10) begin
      winner = PORT1;
    end else if (req == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      winner = PORT0;
`else
      winner = ~last;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a synchronous-read single-port memory (IDLE -> ISSUE [-> RDATA]).
// MEM_ARB_FIXED_PRIO_EN replaces the round-robin last-grant pointer with fixed port-0 priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  arb_state_t        state_reg, state_next;
  logic              owner_reg;
  logic              is_read_reg;
  logic [1:0]        gnt_reg;
  logic [ADDR_W-1:0] mem_address_reg;
  logic [DATA_W-1:0] mem_data_in_reg;
  logic              mem_re_reg;
  logic              mem_we_reg;

  logic [1:0]        req_vec;
  logic [1:0]        rvalid_vec;
  logic [DATA_W-1:0] rdata_arr [NUM_PORTS];
  logic              winner;
  logic              grant_fire;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req_vec = {r1_req, r0_req};

`ifdef MEM_ARB_FIXED_PRIO_EN
  rr_pick2 u_pick (
    .req    (req_vec),
    .winner (winner)
  );
`else
  logic last_reg;

  rr_pick2 u_pick (
    .req    (req_vec),
    .last   (last_reg),
    .winner (winner)
  );
`endif

  assign grant_fire = (state_reg == IDLE) && (|req_vec);
  assign sel_we     = winner ? r1_we    : r0_we;
  assign sel_addr   = winner ? r1_addr  : r0_addr;
  assign sel_wdata  = winner ? r1_wdata : r0_wdata;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req_vec) state_next = ISSUE;
      ISSUE:   state_next = is_read_reg ? RDATA : IDLE;
      RDATA:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Everything facing the memory or a requester is launched from the grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg       <= PORT0;
      is_read_reg     <= 1'b0;
      gnt_reg         <= 2'b00;
      mem_address_reg <= '0;
      mem_data_in_reg <= '0;
      mem_re_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_reg        <= PORT1;
`endif
    end else begin
      gnt_reg    <= 2'b00;
      mem_re_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      if (grant_fire) begin
        owner_reg       <= winner;
        is_read_reg     <= ~sel_we;
        mem_address_reg <= sel_addr;
        mem_data_in_reg <= sel_wdata;
        mem_re_reg      <= ~sel_we;
        mem_we_reg      <= sel_we;
        gnt_reg[winner] <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_reg        <= winner;
`endif
      end
    end
  end

  // Read data is forced to zero outside the owner's RDATA cycle so a floating bus never leaks out.
  genvar gi;
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign rvalid_vec[gi] = (state_reg == RDATA) && (owner_reg == 1'(gi)) && !reset;
    assign rdata_arr[gi]  = rvalid_vec[gi] ? mem_data_out : '0;
  end

  assign r0_gnt           = gnt_reg[0];
  assign r1_gnt           = gnt_reg[1];
  assign r0_rvalid        = rvalid_vec[0];
  assign r1_rvalid        = rvalid_vec[1];
  assign r0_rdata         = rdata_arr[0];
  assign r1_rdata         = rdata_arr[1];
  assign mem_address      = mem_address_reg;
  assign mem_data_in      = mem_data_in_reg;
  assign mem_read_enable  = mem_re_reg;
  assign mem_write_enable = mem_we_reg;
  assign busy             = (state_reg != IDLE);

endmodule
